// File: rtl/smg_score_display_n.sv
// Snake-game score keeper with a multiplexed, leading-zero-blanked 7-segment display.
// Optional high-score display in START is enabled by defining SMG_HISCORE_EN.
module smg_score_display_n #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250,
    parameter int RED_PTS   = 1,
    parameter int GREEN_PTS = 2
) (
    input  logic                  Clk_50mhz,
    input  logic                  Rst_n,
    input  logic                  Body_add_sig,
    input  logic [2:0]            Game_status,
    input  logic                  Apple_type,
    output logic [7:0]            Smg_duan,
    output logic [DIGITS-1:0]     Smg_we,
    output logic [4*DIGITS-1:0]   Score_bcd
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [2:0] ST_START = 3'b001;
    localparam logic [2:0] ST_PLAY  = 3'b010;
    localparam logic [2:0] ST_END   = 3'b100;

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    // Decimal add of a single-digit constant; bit 4*DIGITS is the carry out of the top digit.
    function automatic logic [4*DIGITS:0] bcd_add(input logic [4*DIGITS-1:0] a,
                                                  input logic [3:0] pts);
        logic [4:0]          d;
        logic                c;
        logic [4*DIGITS-1:0] s;
        c = 1'b0;
        s = {(4*DIGITS){1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, pts} : 5'd0) + {4'd0, c};
            if (d > 5'd9) begin
                s[4*i +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                s[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return {c, s};
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    logic [2:0]          sync_r;
    logic                edge_s;
    logic [4*DIGITS-1:0] score_r;
    logic [4*DIGITS:0]   sum_s;
    logic [4*DIGITS-1:0] sum_sat_s;
    logic [3:0]          pts_s;
    logic [2:0]          status_prev_r;
    logic                is_end_s;
    logic                end_entry_s;
    logic [CNT_W-1:0]    scan_cnt_r;
    logic                tick_s;
    logic [IDX_W-1:0]    digit_idx_r;
    logic [BLK_W-1:0]    blink_cnt_r;
    logic                blink_on_r;
    logic [4*DIGITS-1:0] disp_s;
    logic [DIGITS-1:0]   blank_s;
    logic                seen_s;
    logic [3:0]          nib_s;
    logic [7:0]          duan_next_s;
    logic [DIGITS-1:0]   we_next_s;
    logic [7:0]          duan_r;
    logic [DIGITS-1:0]   we_r;

    assign edge_s      = sync_r[1] & ~sync_r[2];
    assign pts_s       = Apple_type ? 4'(GREEN_PTS) : 4'(RED_PTS);
    assign sum_s       = bcd_add(score_r, pts_s);
    assign sum_sat_s   = sum_s[4*DIGITS] ? ALL_NINES : sum_s[4*DIGITS-1:0];
    assign is_end_s    = (Game_status == ST_END);
    assign end_entry_s = is_end_s && (status_prev_r != ST_END);
    assign tick_s      = (scan_cnt_r == CNT_W'(SCAN_DIV - 1));

    // Synchroniser for the apple-eaten level plus one delay stage for edge detection.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_r        <= 3'b000;
            status_prev_r <= 3'b000;
        end else begin
            sync_r        <= {sync_r[1:0], Body_add_sig};
            status_prev_r <= Game_status;
        end
    end

    // Score register: cleared in START, incremented on edges in PLAY, frozen otherwise.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            score_r <= {(4*DIGITS){1'b0}};
        end else if (Game_status == ST_START) begin
            score_r <= {(4*DIGITS){1'b0}};
        end else if ((Game_status == ST_PLAY) && edge_s) begin
            score_r <= sum_sat_s;
        end else begin
            score_r <= score_r;
        end
    end

`ifdef SMG_HISCORE_EN
    logic [4*DIGITS-1:0] hiscore_r;

    // High score captured on entry to END; only the hard reset clears it.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            hiscore_r <= {(4*DIGITS){1'b0}};
        end else if (end_entry_s && (score_r > hiscore_r)) begin
            hiscore_r <= score_r;
        end else begin
            hiscore_r <= hiscore_r;
        end
    end
`endif

    // Scan divider and digit index.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            scan_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
        end else if (tick_s) begin
            scan_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= (digit_idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}}
                                                                 : digit_idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r  <= scan_cnt_r + CNT_W'(1);
            digit_idx_r <= digit_idx_r;
        end
    end

    // Blink phase: only runs in END, restarts in the "on" phase on every entry.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (!is_end_s || end_entry_s) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (tick_s) begin
            if (blink_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_r <= {BLK_W{1'b0}};
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLK_W'(1);
                blink_on_r  <= blink_on_r;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
            blink_on_r  <= blink_on_r;
        end
    end

    // Display value selection, leading-zero blanking and segment/enable decode.
    always_comb begin
        disp_s = score_r;
`ifdef SMG_HISCORE_EN
        if (Game_status == ST_START) begin
            disp_s = hiscore_r;
        end else begin
            disp_s = score_r;
        end
`endif
        seen_s  = 1'b0;
        blank_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_s     = seen_s | (disp_s[4*i +: 4] != 4'd0);
            blank_s[i] = ~seen_s & (i != 0);
        end
        nib_s = disp_s[4*int'(digit_idx_r) +: 4];
        if (blank_s[digit_idx_r]) begin
            duan_next_s = 8'hFF;
        end else begin
            duan_next_s = seg_of(nib_s);
        end
        if (blink_on_r) begin
            we_next_s = ~({{(DIGITS-1){1'b0}}, 1'b1} << digit_idx_r);
        end else begin
            we_next_s = {DIGITS{1'b1}};
        end
    end

    // Registered display outputs so segments and enables switch together.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            duan_r <= 8'hFF;
            we_r   <= {DIGITS{1'b1}};
        end else begin
            duan_r <= duan_next_s;
            we_r   <= we_next_s;
        end
    end

    assign Smg_duan  = duan_r;
    assign Smg_we    = we_r;
    assign Score_bcd = score_r;

endmodule

// File: tb/tb_smg_score_display_n.sv
// Directed self-checking bench for smg_score_display_n (4-digit and 2-digit instances, fast scan).
module tb_smg_score_display_n;

`ifdef SMG_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        body_a = 1'b0, type_a = 1'b0, body_b = 1'b0, type_b = 1'b0;
    logic [2:0]  st_a = 3'b001, st_b = 3'b010;
    logic [7:0]  duan_a, duan_b;
    logic [3:0]  we_a;
    logic [1:0]  we_b;
    logic [15:0] score_a;
    logic [7:0]  score_b;

    int checks = 0;
    int errors = 0;

    smg_score_display_n #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .RED_PTS(1), .GREEN_PTS(2)) dut_a (
        .Clk_50mhz(clk), .Rst_n(rst_n), .Body_add_sig(body_a), .Game_status(st_a),
        .Apple_type(type_a), .Smg_duan(duan_a), .Smg_we(we_a), .Score_bcd(score_a));

    smg_score_display_n #(.DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(2), .RED_PTS(1), .GREEN_PTS(2)) dut_b (
        .Clk_50mhz(clk), .Rst_n(rst_n), .Body_add_sig(body_b), .Game_status(st_b),
        .Apple_type(type_b), .Smg_duan(duan_b), .Smg_we(we_b), .Score_bcd(score_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic green);
        type_a = green;
        body_a = 1'b1;
        repeat (3) step();
        body_a = 1'b0;
        repeat (17) step();
    endtask

    task automatic pulse_b(input logic green);
        type_b = green;
        body_b = 1'b1;
        repeat (3) step();
        body_b = 1'b0;
        repeat (3) step();
    endtask

    // Waits (bounded) until dut_a enables the given digit, then checks its segments.
    task automatic digit_a(input string tag, input logic [3:0] we_exp, input logic [7:0] seg_exp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (we_a == we_exp) found = 1'b1;
        end
        check({tag, "_found"}, 32'(found), 32'h1);
        check({tag, "_seg"}, 32'(duan_a), 32'(seg_exp));
    endtask

    initial begin
        int ones;
        int run;
        int maxrun;

        // Reset state
        repeat (3) step();
        check("rst_we", 32'(we_a), 32'hF);
        check("rst_duan", 32'(duan_a), 32'hFF);
        check("rst_score", 32'(score_a), 32'h0);

        rst_n = 1'b1;
        repeat (100) step();
        check("start_score", 32'(score_a), 32'h0);
        digit_a("start_d0", 4'b1110, 8'hC0);
        digit_a("start_d1", 4'b1101, 8'hFF);
        digit_a("start_d3", 4'b0111, 8'hFF);

        // PLAY: latency of the first red pulse, then 2 red + 2 green
        st_a = 3'b010;
        step();
        type_a = 1'b0;
        body_a = 1'b1;
        step(); step();
        check("lat_2cyc", 32'(score_a), 32'h0);
        step();
        check("lat_3cyc", 32'(score_a), 32'h1);
        body_a = 1'b0;
        repeat (17) step();
        pulse_a(1'b0);
        pulse_a(1'b0);
        pulse_a(1'b1);
        pulse_a(1'b1);
        check("play_7", 32'(score_a), 32'h7);
        digit_a("play7_d0", 4'b1110, 8'hF8);
        digit_a("play7_d1", 4'b1101, 8'hFF);

        pulse_a(1'b1);
        pulse_a(1'b1);
        pulse_a(1'b0);
        check("play_12", 32'(score_a), 32'h12);
        digit_a("play12_d0", 4'b1110, 8'hA4);
        digit_a("play12_d1", 4'b1101, 8'hF9);
        digit_a("play12_d2", 4'b1011, 8'hFF);

        // Saturation on the 2-digit instance
        for (int i = 0; i < 49; i++) pulse_b(1'b1);
        check("b_98", 32'(score_b), 32'h98);
        pulse_b(1'b1);
        check("b_sat_99", 32'(score_b), 32'h99);
        pulse_b(1'b0);
        check("b_hold_99", 32'(score_b), 32'h99);

        // END: starts in "on" phase, pulses ignored, blinks 8 off every 16
        st_a = 3'b100;
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (we_a == 4'b1111) ones++;
        end
        check("end_starts_on", 32'(ones), 32'h0);
        pulse_a(1'b1);
        check("end_frozen", 32'(score_a), 32'h12);
        ones = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (we_a == 4'b1111) begin
                ones++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("blink_off_total", 32'(ones), 32'd24);
        check("blink_off_run", 32'(maxrun), 32'd8);

        // Non-one-hot status: frozen score, steady display
        st_a = 3'b011;
        step(); step();
        pulse_a(1'b0);
        check("bad_frozen", 32'(score_a), 32'h12);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (we_a == 4'b1111) ones++;
        end
        check("bad_steady", 32'(ones), 32'h0);

        // START coincident with a pulse, then a pulse inside START
        st_a = 3'b001;
        body_a = 1'b1;
        repeat (3) step();
        body_a = 1'b0;
        repeat (3) step();
        check("start_coinc", 32'(score_a), 32'h0);
        pulse_a(1'b1);
        check("start_pulse", 32'(score_a), 32'h0);
        digit_a("start2_d0", 4'b1110, HS ? 8'hA4 : 8'hC0);
        digit_a("start2_d1", 4'b1101, HS ? 8'hF9 : 8'hFF);

        // Reset mid-addition and mid-scan
        st_a = 3'b010;
        step();
        type_a = 1'b1;
        body_a = 1'b1;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(we_a), 32'hF);
        check("mid_rst_duan", 32'(duan_a), 32'hFF);
        check("mid_rst_score", 32'(score_a), 32'h0);
        body_a = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rel_d0_first", 32'(we_a), 32'hE);
        repeat (3) step();
        check("rel_d0_last", 32'(we_a), 32'hE);
        step();
        check("rel_d1", 32'(we_a), 32'hD);
        repeat (5) step();
        check("rel_aborted", 32'(score_a), 32'h0);

        // High score (if present) cleared by reset
        st_a = 3'b001;
        digit_a("rst_hs_d0", 4'b1110, 8'hC0);
        digit_a("rst_hs_d1", 4'b1101, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
